// File: rtl/uart_tx_frame_if.sv
// Parallel-side request and serial-side status signals of the UART frame transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// each held for Prescale clocks; request parameters are latched on accept.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_frame_if.slave  bus
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_nx;
    logic [4:0]            edge_cnt, edge_nx;
    logic [4:0]            pmax_q, pmax_nx;
    logic [BIT_W-1:0]      bit_cnt, bit_nx;
    logic [BIT_W-1:0]      bit_inc;
    logic [DATA_WIDTH-1:0] data_q, data_nx;
    logic                  par_en_q, par_en_nx;
    logic                  par_bit_q, par_bit_nx;
    logic                  tx_q, tx_nx;
    logic                  busy_q, busy_nx;
    logic [31:0]           p_in;
    logic                  p_legal;
    logic                  edge_last;

    assign p_in      = 32'(bus.Prescale);
    assign p_legal   = (p_in == 32'd8) || (p_in == 32'd16) || (p_in == 32'd32);
    assign edge_last = (edge_cnt == pmax_q);
    assign bit_inc   = bit_cnt + 1'b1;

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            pmax_q    <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            edge_cnt  <= edge_nx;
            pmax_q    <= pmax_nx;
            bit_cnt   <= bit_nx;
            data_q    <= data_nx;
            par_en_q  <= par_en_nx;
            par_bit_q <= par_bit_nx;
            tx_q      <= tx_nx;
            busy_q    <= busy_nx;
        end
    end

    // The line value for the next bit is loaded on the edge that ends the
    // current one, so TX_OUT stays a pure register output.
    always_comb begin
        state_nx   = state;
        edge_nx    = edge_cnt;
        pmax_nx    = pmax_q;
        bit_nx     = bit_cnt;
        data_nx    = data_q;
        par_en_nx  = par_en_q;
        par_bit_nx = par_bit_q;
        tx_nx      = tx_q;
        busy_nx    = busy_q;

        unique case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                edge_nx = '0;
                bit_nx  = '0;
                if (bus.Data_Valid && p_legal) begin
                    data_nx    = bus.P_DATA;
                    par_en_nx  = bus.PAR_EN;
                    par_bit_nx = (^bus.P_DATA) ^ bus.PAR_TYP;
                    pmax_nx    = 5'(p_in - 32'd1);
                    state_nx   = START;
                    tx_nx      = 1'b0;
                    busy_nx    = 1'b1;
                end
            end

            START: begin
                if (edge_last) begin
                    edge_nx  = '0;
                    bit_nx   = '0;
                    state_nx = DATA;
                    tx_nx    = data_q[0];
                end else begin
                    edge_nx = edge_cnt + 5'd1;
                end
            end

            DATA: begin
                if (edge_last) begin
                    edge_nx = '0;
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_nx = '0;
                        if (par_en_q) begin
                            state_nx = PARITY;
                            tx_nx    = par_bit_q;
                        end else begin
                            state_nx = STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_nx = bit_inc;
                        tx_nx  = data_q[bit_inc];
                    end
                end else begin
                    edge_nx = edge_cnt + 5'd1;
                end
            end

            PARITY: begin
                if (edge_last) begin
                    edge_nx  = '0;
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end else begin
                    edge_nx = edge_cnt + 5'd1;
                end
            end

            STOP: begin
                tx_nx = 1'b1;
                if (edge_last) begin
                    edge_nx  = '0;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    edge_nx = edge_cnt + 5'd1;
                end
            end

            default: begin
                state_nx = IDLE;
                edge_nx  = '0;
                bit_nx   = '0;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed checks of uart_tx_frame: framing, parity, timing, input latching,
// illegal prescale rejection and asynchronous reset.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_tx_frame_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, bus.TX_OUT, 1'b1);
        check({tag, "_busy"}, bus.Busy, 1'b0);
    endtask

    // Caller has set up the request; accept happens on the next rising edge.
    // len is the hand-computed frame length in cycles; par the expected parity.
    task automatic frame(input string tag, input logic [7:0] d, input bit pe,
                         input logic par, input int p, input int len,
                         input bit drop_dv, input bit tamper);
        logic [10:0] seq;
        seq = pe ? {1'b1, par, d, 1'b0} : {1'b0, 1'b1, d, 1'b0};
        @(posedge clk); #1;
        for (int c = 0; c < len; c++) begin
            check($sformatf("%s_tx_c%0d", tag, c), bus.TX_OUT, seq[c / p]);
            check($sformatf("%s_busy_c%0d", tag, c), bus.Busy, 1'b1);
            if (c == 0 && drop_dv) bus.Data_Valid = 1'b0;
            if (tamper && c == 5) begin
                bus.P_DATA     = 8'hFF;
                bus.Prescale   = 6'd8;
                bus.PAR_EN     = ~bus.PAR_EN;
                bus.PAR_TYP    = ~bus.PAR_TYP;
                bus.Data_Valid = 1'b1;
            end
            if (tamper && c == 6) bus.Data_Valid = 1'b0;
            @(posedge clk); #1;
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        bus.P_DATA     = 8'hA5;
        bus.Data_Valid = 1'b1;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd8;

        // Reset held with a valid request pending: no frame may start.
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        bus.Data_Valid = 1'b0;
        @(posedge clk); #1;
        check_idle("post_reset");

        // 1: P=8, 0xA5, no parity, 80 cycles.
        bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
        bus.Data_Valid = 1'b1;
        frame("t1", 8'hA5, 1'b0, 1'b0, 8, 80, 1'b1, 1'b0);

        // 2: P=16, 0xA5 with even then odd parity, 176 cycles.
        bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Prescale = 6'd16;
        bus.Data_Valid = 1'b1;
        frame("t2e", 8'hA5, 1'b1, 1'b0, 16, 176, 1'b1, 1'b0);
        bus.PAR_TYP = 1'b1;
        bus.Data_Valid = 1'b1;
        frame("t2o", 8'hA5, 1'b1, 1'b1, 16, 176, 1'b1, 1'b0);

        // 3: P=32, 0x01, even parity = 1; inputs disturbed mid-frame.
        bus.P_DATA = 8'h01; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        bus.Prescale = 6'd32;
        bus.Data_Valid = 1'b1;
        frame("t3", 8'h01, 1'b1, 1'b1, 32, 352, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_idle("t3_no_queue");

        // 4: Data_Valid held across two frames, one idle cycle between.
        bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.Prescale = 6'd8;
        bus.Data_Valid = 1'b1;
        frame("t4a", 8'h3C, 1'b0, 1'b0, 8, 80, 1'b0, 1'b0);
        bus.P_DATA = 8'hC3;
        frame("t4b", 8'hC3, 1'b0, 1'b0, 8, 80, 1'b1, 1'b0);

        // 5: illegal prescale values are dropped; legal one starts at once.
        bus.P_DATA = 8'h5A; bus.Prescale = 6'd10; bus.Data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("t5_p10_%0d", i));
        end
        bus.Prescale = 6'd0;
        @(posedge clk); #1;
        check_idle("t5_p0");
        bus.Prescale = 6'd8;
        frame("t5", 8'h5A, 1'b0, 1'b0, 8, 80, 1'b1, 1'b0);

        // 6: reset during data bit 4 (cycles 80..95 at P=16); A5 bit4 is 0.
        bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b0; bus.Prescale = 6'd16;
        bus.Data_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Data_Valid = 1'b0;
        check("t6_start_tx", bus.TX_OUT, 1'b0);
        repeat (84) begin
            @(posedge clk); #1;
        end
        check("t6_bit4_tx", bus.TX_OUT, 1'b0);
        check("t6_bit4_busy", bus.Busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_idle("t6_async");
        bus.Prescale = 6'd8;
        bus.Data_Valid = 1'b1;
        @(posedge clk); #1;
        check_idle("t6_rst_wins");
        rst = 1'b0;
        bus.Data_Valid = 1'b0;
        @(posedge clk); #1;
        check_idle("t6_released");
        bus.P_DATA = 8'h5A; bus.Prescale = 6'd16;
        bus.Data_Valid = 1'b1;
        frame("t6", 8'h5A, 1'b0, 1'b0, 16, 160, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter that serializes one parallel byte per request into a framed asynchronous serial stream. Frame order: start bit, 8 data bits LSB first, optional parity bit, one stop bit. Each bit is held for Prescale clock cycles, so TX shares the same clock/Prescale scheme as the RX side. Sits between the system-side data source and the serial line `TX_OUT`.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of Prescale input

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled on accept
Data_Valid  input  1  transmit request; accepted only when Busy=0 and state IDLE
PAR_EN  input  1  1 = insert parity bit; sampled on accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept
Prescale  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32; sampled on accept
TX_OUT  output  1  serial line; idle high
Busy  output  1  high while a frame is in progress

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset, asynchronous, also mid-frame:
  - TX_OUT=1, Busy=0 immediately on assertion.
  - FSM goes to IDLE; edge counter and bit counter cleared; latched registers cleared.
  - A partial frame is abandoned. There is no resumption after reset release.
- Registered outputs: TX_OUT and Busy are registers. There is no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE
    - TX_OUT=1, Busy=0.
    - On a rising edge with Data_Valid=1 and Prescale in {8,16,32}:
      - latch P_DATA, PAR_EN, PAR_TYP, Prescale;
      - compute parity;
      - go to START; TX_OUT<=0 and Busy<=1 on that same edge.
    - Data_Valid=1 with an illegal Prescale (any other value, including 0): request dropped, remain IDLE, no output change.
  - START: TX_OUT=0 for P cycles, then go to DATA.
  - DATA
    - Transmit latched bit[i], i = 0..DATA_WIDTH-1, each for P cycles.
    - After bit 7: go to PARITY if PAR_EN was latched 1, else go to STOP.
  - PARITY
    - TX_OUT = XOR of the latched data when PAR_TYP=0 (even).
    - TX_OUT = inverted XOR when PAR_TYP=1 (odd).
    - Held for P cycles, then go to STOP.
  - STOP: TX_OUT=1 for P cycles. On the last stop cycle's edge: go to IDLE, Busy<=0.
- Timing:
  - Frame length = (10 + PAR_EN) × P cycles, measured from the accept edge to the edge where Busy falls.
  - At least one IDLE cycle (TX_OUT=1, Busy=0) separates back-to-back frames.
  - Data_Valid held high continuously is accepted in that IDLE cycle.
- Counters:
  - Edge counter is 5 bits and counts 0..P-1. On reaching P-1 it wraps to 0 and advances the bit/state. It never exceeds 31.
  - Bit counter is 3 bits, valid only in DATA, and wraps 7→0 on exit.
- Input stability:
  - Data_Valid, P_DATA, PAR_EN, PAR_TYP and Prescale changes while Busy=1 are ignored; the latched copies are used.
  - A Data_Valid pulse while Busy=1 is lost. It is not queued.
- Simultaneous events: reset asserted together with Data_Valid → reset wins, no frame starts.

Test Plan:
1. P=8, P_DATA=0xA5, PAR_EN=0 → TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; Busy high exactly 80 cycles; TX_OUT=1, Busy=0 afterwards.
2. P=16, P_DATA=0xA5, PAR_EN=1:
   - PAR_TYP=0 → parity bit 0, frame 176 cycles.
   - Repeat with PAR_TYP=1 → parity bit 1.
3. P=32, P_DATA=0x01, PAR_EN=1, PAR_TYP=0 → parity 1; frame 352 cycles. Change P_DATA to 0xFF and Prescale to 8 mid-frame → waveform unchanged.
4. Data_Valid held high, P_DATA=0x3C then 0xC3, P=8, no parity → two 80-cycle frames separated by exactly one idle cycle, correct bytes.
5. Prescale=10 with Data_Valid=1 → no start bit, Busy stays 0. Then Prescale=8 → frame starts on that edge.
6. Assert rst during data bit 4 of a P=16 frame → TX_OUT=1, Busy=0 immediately. After release, new request 0x5A transmits a clean full frame.
